// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the instruction cache and its memory port.
//   - Address split for a 10-bit fetch byte address:
//       [9:7] tag | [6:4] index | [3:2] word | [1:0] byte (ignored)
//   - {tag,index} is the 6-bit block address seen by instruction memory.
//   - Cache controller state encoding.
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int ICACHE_LINES      = 8;
    localparam int ICACHE_BLOCK_BITS = 128;
    localparam int ICACHE_ADDR_BITS  = 10;
    localparam int ICACHE_WORD_W     = 32;                          // instruction width
    localparam int ICACHE_WOFF_W     = 2;                           // word-in-line select width
    localparam int ICACHE_OFF_W      = 4;                           // byte offset inside a line
    localparam int ICACHE_IDX_W      = $clog2(ICACHE_LINES);
    localparam int ICACHE_TAG_W      = ICACHE_ADDR_BITS - ICACHE_OFF_W - ICACHE_IDX_W;
    localparam int IMEM_BLK_ADDR_W   = ICACHE_TAG_W + ICACHE_IDX_W;

    typedef enum logic [1:0] {
        ICS_IDLE     = 2'd0,
        ICS_MEM_READ = 2'd1,
        ICS_UPDATE   = 2'd2
    } icache_state_t;

    // Pick 32-bit word w out of a line; word 0 sits in the low bits.
    function automatic logic [ICACHE_WORD_W-1:0] icache_word_sel(
        input logic [ICACHE_BLOCK_BITS-1:0] blk,
        input logic [ICACHE_WOFF_W-1:0]     w
    );
        return blk[{w, 5'b0} +: ICACHE_WORD_W];
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// -----------------------------------------------------------------------------
// instruction_cache_if
// Bundles the fetch-side request/response and the instruction-memory
// read/busywait handshake of the instruction cache.
//   Fetch side : read, address -> instruction, busywait
//   Memory side: mem_read, mem_address -> mem_readinst, mem_busywait
// Modports:
//   slave  - the cache itself
//   master - the environment (fetch stage + instruction memory)
// -----------------------------------------------------------------------------
interface instruction_cache_if;
    import cpu_pkg::*;

    logic                          read;
    logic [ICACHE_ADDR_BITS-1:0]   address;
    logic [ICACHE_WORD_W-1:0]      instruction;
    logic                          busywait;
    logic                          mem_read;
    logic [IMEM_BLK_ADDR_W-1:0]    mem_address;
    logic [ICACHE_BLOCK_BITS-1:0]  mem_readinst;
    logic                          mem_busywait;

    modport slave (
        input  read, address, mem_readinst, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );

    modport master (
        output read, address, mem_readinst, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );

endinterface

// File: rtl/icache_line_store.sv
// -----------------------------------------------------------------------------
// icache_line_store
// Valid / tag / data storage for the direct-mapped instruction cache.
//   clock, reset : system clock, synchronous active-high reset (clears valids)
//   rd_idx       : lookup index, read asynchronously
//   rd_valid/rd_tag/rd_data : contents of line rd_idx
//   wr_en, wr_idx, wr_tag, wr_data : line fill, written on the clock edge
// Data and tags are not reset; an invalid line is never reported as a hit.
// -----------------------------------------------------------------------------
module icache_line_store
    import cpu_pkg::*;
(
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ICACHE_IDX_W-1:0]      rd_idx,
    output logic                         rd_valid,
    output logic [ICACHE_TAG_W-1:0]      rd_tag,
    output logic [ICACHE_BLOCK_BITS-1:0] rd_data,
    input  logic                         wr_en,
    input  logic [ICACHE_IDX_W-1:0]      wr_idx,
    input  logic [ICACHE_TAG_W-1:0]      wr_tag,
    input  logic [ICACHE_BLOCK_BITS-1:0] wr_data
);

    logic [ICACHE_LINES-1:0]      valid_q;
    logic [ICACHE_LINES-1:0]      valid_d;
    logic [ICACHE_TAG_W-1:0]      tag_q  [ICACHE_LINES];
    logic [ICACHE_BLOCK_BITS-1:0] data_q [ICACHE_LINES];
    logic [ICACHE_LINES-1:0]      line_we;

    // One-hot write enable per line.
    for (genvar gi = 0; gi < ICACHE_LINES; gi++) begin : g_line_we
        assign line_we[gi] = wr_en && (wr_idx == ICACHE_IDX_W'(gi));
    end

    always_comb begin
        valid_d = valid_q | line_we;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < ICACHE_LINES; i++) begin
            if (line_we[i]) begin
                tag_q[i]  <= wr_tag;
                data_q[i] <= wr_data;
            end
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// -----------------------------------------------------------------------------
// instruction_cache
// Direct-mapped, read-only instruction cache (8 lines x 128 bits) between
// the fetch stage and 128-bit-block instruction memory.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : read/address -> instruction/busywait on the fetch side,
//                  mem_read/mem_address <- mem_readinst/mem_busywait on memory
// Hits return the selected word combinationally. A miss stalls fetch, reads
// one block, fills the line in a single UPDATE cycle and then re-evaluates
// whatever address is presented at that point.
// Optional: define ICACHE_STATS_EN to add saturating 16-bit hit_count and
// miss_count outputs.
// -----------------------------------------------------------------------------
module instruction_cache
    import cpu_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    instruction_cache_if.slave   bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    logic [ICACHE_TAG_W-1:0]      addr_tag;
    logic [ICACHE_IDX_W-1:0]      addr_idx;
    logic [ICACHE_WOFF_W-1:0]     addr_word;
    logic                         unused_addr_bits;

    logic                         line_valid;
    logic [ICACHE_TAG_W-1:0]      line_tag;
    logic [ICACHE_BLOCK_BITS-1:0] line_data;

    icache_state_t                state_q, state_d;
    logic                         seen_busy_q, seen_busy_d;
    logic                         mem_read_q, mem_read_d;
    logic [IMEM_BLK_ADDR_W-1:0]   miss_addr_q, miss_addr_d;
    logic [ICACHE_WORD_W-1:0]     instr_q, instr_d;

    logic                         hit;
    logic                         idle_hit;
    logic                         miss_start;
    logic [ICACHE_WORD_W-1:0]     hit_word;
    logic                         fill_en;

    assign addr_word        = bus.address[ICACHE_OFF_W-1 -: ICACHE_WOFF_W];
    assign addr_idx         = bus.address[ICACHE_OFF_W +: ICACHE_IDX_W];
    assign addr_tag         = bus.address[ICACHE_ADDR_BITS-1 -: ICACHE_TAG_W];
    assign unused_addr_bits = ^bus.address[1:0];

    icache_line_store u_line_store (
        .clock    (clock),
        .reset    (reset),
        .rd_idx   (addr_idx),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (line_data),
        .wr_en    (fill_en),
        .wr_idx   (miss_addr_q[ICACHE_IDX_W-1:0]),
        .wr_tag   (miss_addr_q[IMEM_BLK_ADDR_W-1 -: ICACHE_TAG_W]),
        .wr_data  (bus.mem_readinst)
    );

    assign hit        = bus.read && line_valid && (line_tag == addr_tag);
    assign hit_word   = icache_word_sel(line_data, addr_word);
    assign idle_hit   = (state_q == ICS_IDLE) && hit;
    assign miss_start = (state_q == ICS_IDLE) && bus.read && !hit;
    // Memory data is held valid through UPDATE, so the fill is taken there.
    assign fill_en    = (state_q == ICS_UPDATE);

    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        mem_read_d  = mem_read_q;
        miss_addr_d = miss_addr_q;
        instr_d     = idle_hit ? hit_word : instr_q;

        case (state_q)
            ICS_IDLE: begin
                if (miss_start) begin
                    state_d     = ICS_MEM_READ;
                    miss_addr_d = {addr_tag, addr_idx};
                    mem_read_d  = 1'b1;
                    seen_busy_d = 1'b0;
                end
            end
            ICS_MEM_READ: begin
                // Memory must first acknowledge with busywait high; a low
                // level before that is not yet the end of this transfer.
                if (bus.mem_busywait) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q) begin
                    state_d    = ICS_UPDATE;
                    mem_read_d = 1'b0;
                end
            end
            ICS_UPDATE: begin
                state_d = ICS_IDLE;
            end
            default: begin
                state_d    = ICS_IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ICS_IDLE;
            seen_busy_q <= 1'b0;
            mem_read_q  <= 1'b0;
            miss_addr_q <= '0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
            mem_read_q  <= mem_read_d;
            miss_addr_q <= miss_addr_d;
            instr_q     <= instr_d;
        end
    end

    // Outside IDLE the request is always stalled; in IDLE only a miss stalls.
    assign bus.busywait    = (state_q == ICS_IDLE) ? (bus.read && !hit) : 1'b1;
    assign bus.instruction = idle_hit ? hit_word : instr_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_address = miss_addr_q;

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (idle_hit && (hit_count_q != 16'hFFFF)) begin
            hit_count_d = hit_count_q + 16'd1;
        end
        if (miss_start && (miss_count_q != 16'hFFFF)) begin
            miss_count_d = miss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
